// File: rtl/ex_muldiv_if.sv
// -----------------------------------------------------------------------------
// ex_muldiv_if
// Purpose : Bundles the ID/EX-side operands of the HI/LO unit together with the
//           results and stall it returns to the pipeline.
// Signals :
//   valid_id_ex     ID/EX holds a real instruction (0 for bubbles)
//   opcode_id_ex    opcode from ID/EX
//   func_id_ex      function field from ID/EX
//   rd0_data_id_ex  rs operand (dividend / multiplicand / MTHI-MTLO source)
//   rd1_data_id_ex  rt operand (divisor / multiplier)
//   busy            iterative multiply/divide in progress
//   stall           EX instruction must be held and re-presented
//   hilo_rd_data    HI for MFHI, LO for MFLO, else 0
//   hi, lo          architectural HI/LO registers
// Modports: master = pipeline side, slave = ex_muldiv.
// -----------------------------------------------------------------------------
interface ex_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             valid_id_ex;
   logic [5:0]       opcode_id_ex;
   logic [5:0]       func_id_ex;
   logic [WIDTH-1:0] rd0_data_id_ex;
   logic [WIDTH-1:0] rd1_data_id_ex;
   logic             busy;
   logic             stall;
   logic [WIDTH-1:0] hilo_rd_data;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output valid_id_ex, opcode_id_ex, func_id_ex, rd0_data_id_ex, rd1_data_id_ex,
      input  busy, stall, hilo_rd_data, hi, lo
   );

   modport slave (
      input  valid_id_ex, opcode_id_ex, func_id_ex, rd0_data_id_ex, rd1_data_id_ex,
      output busy, stall, hilo_rd_data, hi, lo
   );
endinterface

// File: rtl/ex_muldiv.sv
// -----------------------------------------------------------------------------
// ex_muldiv
// Purpose : Execute-stage HI/LO unit. Decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO/
//           MTHI/MTLO from ID/EX, runs multiply (shift-add) and divide
//           (restoring) one bit per cycle, and owns the HI/LO registers.
// Ports   :
//   clk  pipeline clock
//   rst  synchronous active-high reset
//   bus  ex_muldiv_if.slave (ID/EX operands in; busy/stall/hilo_rd_data/hi/lo out)
// -----------------------------------------------------------------------------
module ex_muldiv #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input logic        clk,
   input logic        rst,
   ex_muldiv_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

   state_e               r_state;
   state_e               w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_acc;    // mul: {partial product, multiplier}; div: quotient in low half
   logic [WIDTH-1:0]     r_opb;    // mul: multiplicand; div: divisor
   logic [WIDTH-1:0]     r_rem;
   logic                 r_is_div;
   logic                 r_sgn_a;  // operand signs, already zero for unsigned ops
   logic                 r_sgn_b;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;

   // Decode
   logic w_dec, w_mult, w_multu, w_div, w_divu, w_mfhi, w_mthi, w_mflo, w_mtlo;
   logic w_is_mul, w_is_div, w_signed, w_hilo_op, w_busy, w_start;

   assign w_dec     = bus.valid_id_ex && (bus.opcode_id_ex == 6'h00);
   assign w_mult    = w_dec && (bus.func_id_ex == 6'h18);
   assign w_multu   = w_dec && (bus.func_id_ex == 6'h19);
   assign w_div     = w_dec && (bus.func_id_ex == 6'h1A);
   assign w_divu    = w_dec && (bus.func_id_ex == 6'h1B);
   assign w_mfhi    = w_dec && (bus.func_id_ex == 6'h10);
   assign w_mthi    = w_dec && (bus.func_id_ex == 6'h11);
   assign w_mflo    = w_dec && (bus.func_id_ex == 6'h12);
   assign w_mtlo    = w_dec && (bus.func_id_ex == 6'h13);
   assign w_is_mul  = w_mult || w_multu;
   assign w_is_div  = w_div || w_divu;
   assign w_signed  = w_mult || w_div;
   assign w_hilo_op = w_is_mul || w_is_div || w_mfhi || w_mthi || w_mflo || w_mtlo;
   assign w_busy    = (r_state != StIdle);
   // Divide by zero is silently dropped: HI/LO stay put and the unit never goes busy.
   assign w_start   = !w_busy && (w_is_mul || (w_is_div && (bus.rd1_data_id_ex != '0)));

   logic [WIDTH-1:0] w_rs_abs, w_rt_abs;
   assign w_rs_abs = (w_signed && bus.rd0_data_id_ex[WIDTH-1]) ? -bus.rd0_data_id_ex
                                                               : bus.rd0_data_id_ex;
   assign w_rt_abs = (w_signed && bus.rd1_data_id_ex[WIDTH-1]) ? -bus.rd1_data_id_ex
                                                               : bus.rd1_data_id_ex;

   // Shift-add step: add multiplicand into the upper half when the current
   // multiplier bit is set, then shift the whole accumulator right by one.
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_mul_nxt;
   assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
   assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

   // Restoring divide step on a WIDTH+1-bit partial remainder.
   logic [WIDTH:0]   w_div_shift;
   logic             w_div_ge;
   logic [WIDTH-1:0] w_div_diff;
   assign w_div_shift = {r_rem, r_acc[WIDTH-1]};
   assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
   assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opb;

   // Sign correction applied in StFix.
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;
   assign w_prod_fix = (r_sgn_a ^ r_sgn_b) ? -r_acc : r_acc;
   assign w_quo_fix  = (r_sgn_a ^ r_sgn_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem_fix  = r_sgn_a ? -r_rem : r_rem;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= StIdle;
      else     r_state <= w_state_nxt;
   end

   // FSM next state
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (w_start) w_state_nxt = StRun;
         StRun:   if (r_cnt == CNT_LAST) w_state_nxt = StFix;
         StFix:   w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   // Datapath and HI/LO
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opb    <= '0;
         r_rem    <= '0;
         r_is_div <= 1'b0;
         r_sgn_a  <= 1'b0;
         r_sgn_b  <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_start) begin
                  r_cnt    <= '0;
                  r_is_div <= w_is_div;
                  r_sgn_a  <= w_signed && bus.rd0_data_id_ex[WIDTH-1];
                  r_sgn_b  <= w_signed && bus.rd1_data_id_ex[WIDTH-1];
                  r_rem    <= '0;
                  r_opb    <= w_is_div ? w_rt_abs : w_rs_abs;
                  r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_rs_abs : w_rt_abs)};
               end else if (w_mthi) begin
                  r_hi <= bus.rd0_data_id_ex;
               end else if (w_mtlo) begin
                  r_lo <= bus.rd0_data_id_ex;
               end
            end
            StRun: begin
               r_cnt <= r_cnt + CNT_ONE;
               if (r_is_div) begin
                  r_rem              <= w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
                  r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], w_div_ge};
               end else begin
                  r_acc <= w_mul_nxt;
               end
            end
            StFix: begin
               if (r_is_div) begin
                  r_lo <= w_quo_fix;
                  r_hi <= w_rem_fix;
               end else begin
                  r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod_fix[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy         = w_busy;
   assign bus.stall        = w_busy && w_hilo_op;
   assign bus.hilo_rd_data = w_mfhi ? r_hi : (w_mflo ? r_lo : '0);
   assign bus.hi           = r_hi;
   assign bus.lo           = r_lo;

endmodule
